// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane decode used by
// the wait-state slave template.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [5:0] ID_INDEX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Little-endian byte-lane enables for a transfer of the given size/offset.
    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahblite_slave_ctrl.sv
// Address-phase capture, error classification, wait counter and response FSM
// for the AHB-Lite wait-state slave.
module ahblite_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned NUM_REGS    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hsel_i,
    input  logic       hready_i,
    input  logic       trans_active_i,
    input  logic [7:0] haddr_i,
    input  logic [2:0] hsize_i,
    input  logic       hwrite_i,
    output logic       commit_o,
    output logic       write_o,
    output logic [5:0] idx_o,
    output logic [3:0] be_o,
    output logic       hreadyout_o,
    output logic       hresp_o
);

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);

    slv_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic [7:0] addr_q, addr_d;
    logic [2:0] size_q, size_d;
    logic       write_q, write_d;
    logic       sample_s;
    logic       err_s;
    logic [5:0] idx_s;

    assign idx_s    = haddr_i[7:2];
    assign sample_s = hsel_i & hready_i & trans_active_i
                    & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

    assign err_s = (hsize_i > HSIZE_WORD)
                 | ((hsize_i == HSIZE_HALF) & haddr_i[0])
                 | ((hsize_i == HSIZE_WORD) & (haddr_i[1:0] != 2'b00))
                 | (({1'b0, idx_s} >= NUM_REGS_L) & (idx_s != ID_INDEX))
                 | (hwrite_i & (idx_s == ID_INDEX));

    // Next-state logic; ERR2 accepts a new address phase just like IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = 1'b0;
        addr_d    = addr_q;
        size_d    = size_q;
        write_d   = write_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (sample_s) begin
                    addr_d  = haddr_i;
                    size_d  = hsize_i;
                    write_d = hwrite_i;
                    if (err_s) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        pending_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = ST_IDLE;
                    pending_d = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured address-phase registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pending_q <= 1'b0;
            addr_q    <= 8'd0;
            size_q    <= 3'd0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            write_q   <= write_d;
        end
    end

    assign commit_o    = pending_q;
    assign write_o     = write_q;
    assign idx_o       = addr_q[7:2];
    assign be_o        = lane_enable(size_q, addr_q[1:0]);
    assign hreadyout_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahblite_waitstate_slave.sv
// AHB-Lite slave with a small read/write register bank, a read-only ID word,
// programmable OKAY wait states and two-cycle ERROR responses.
module ahblite_waitstate_slave
    import ahb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] ID_VALUE    = 32'h5A5A_0001
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic                     HWRITE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [31:0]              HRDATA,
    output logic [32*NUM_REGS-1:0]   REG_OUT
);

    logic [31:0] regs_q [NUM_REGS];
    logic        commit_s;
    logic        write_s;
    logic [5:0]  idx_s;
    logic [3:0]  be_s;
    logic [31:0] rdata_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^{HADDR[31:8], HTRANS[0]};

    ahblite_slave_ctrl #(
        .WAIT_STATES (WAIT_STATES),
        .NUM_REGS    (NUM_REGS)
    ) u_ctrl (
        .clk_i          (HCLK),
        .rst_ni         (HRESETn),
        .hsel_i         (HSEL),
        .hready_i       (HREADY),
        .trans_active_i (HTRANS[1]),
        .haddr_i        (HADDR[7:0]),
        .hsize_i        (HSIZE),
        .hwrite_i       (HWRITE),
        .commit_o       (commit_s),
        .write_o        (write_s),
        .idx_o          (idx_s),
        .be_o           (be_s),
        .hreadyout_o    (HREADYOUT),
        .hresp_o        (HRESP)
    );

    // Byte-lane merge of write data into the addressed register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (commit_s && write_s && (idx_s == 6'(i)) && be_s[b]) begin
                        regs_q[i][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read data is driven only in the completing cycle of an OKAY read
    always_comb begin
        rdata_s = 32'h0;
        if (commit_s && !write_s) begin
            if (idx_s == ID_INDEX) begin
                rdata_s = ID_VALUE;
            end else begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    rdata_s = (idx_s == 6'(i)) ? regs_q[i] : rdata_s;
                end
            end
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign HRDATA = rdata_s;

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs_q[g];
    end

endmodule

// File: doc/ahblite_waitstate_slave.md
Name: ahblite_waitstate_slave

Overview:
- AHB-Lite responder holding a small bank of 32-bit control registers plus a read-only ID word.
- Drives HREADYOUT/HRESP/HRDATA into one port of the system slave response multiplexer.
- Inserts a programmable number of wait states on OKAY transfers.
- Returns the standard two-cycle ERROR response for illegal accesses.
- Serves as the canonical slave template and bench target for exercising the bus fabric's stall and error paths.

Parameters:
- WAIT_STATES, 1, data-phase wait cycles inserted before an OKAY completion (legal range 0..15).
- NUM_REGS, 8, number of read/write registers at word indices 0..NUM_REGS-1 (legal range 1..32).
- ID_VALUE, 32'h5A5A_0001, constant returned at word index 63.

Ports:
- HCLK  input  1  bus clock
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select from address decoder
- HADDR  input  32  transfer address; only bits [7:0] decoded
- HTRANS  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HSIZE  input  3  transfer size (0=byte, 1=half, 2=word)
- HWRITE  input  1  1=write, 0=read
- HWDATA  input  32  write data, data phase
- HREADY  input  1  fabric-level ready (muxed HREADYOUT of the active slave)
- HREADYOUT  output  1  this slave's ready
- HRESP  output  1  0=OKAY, 1=ERROR
- HRDATA  output  32  read data
- REG_OUT  output  32*NUM_REGS  flat register bank contents; register i at bits [32i+31:32i]

Behaviour:
- Reset (HRESETn low, asynchronous) values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, all registers 0, FSM in IDLE.
  - Reset asserted mid-transfer aborts the transfer; no register write occurs.
- Address-phase accept: sample = HSEL & HREADY & HTRANS[1] at a rising edge.
  - On sample, capture HADDR[7:0], HSIZE, HWRITE.
  - Nothing is captured while HREADY is low, including while another slave stalls.
  - IDLE/BUSY or unselected cycles produce a zero-wait OKAY with no side effect.
- Error classification, evaluated at sample; any true condition gives ERROR:
  - HSIZE > 2.
  - HSIZE=1 with HADDR[0]=1.
  - HSIZE=2 with HADDR[1:0] != 0.
  - Word index HADDR[7:2] outside 0..NUM_REGS-1 and not 63.
  - Write to index 63.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: HREADYOUT=1, HRESP=0.
    - OKAY sample with WAIT_STATES>0 -> WAIT with counter=WAIT_STATES.
    - OKAY sample with WAIT_STATES=0 -> stay IDLE; the next cycle is the completing data phase.
    - Error sample -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements each cycle.
    - At counter=1, move to the completing cycle: HREADYOUT=1, return to IDLE behaviour with the pending flag set.
    - Exactly WAIT_STATES low cycles precede the completion cycle.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. No wait states are inserted before an error.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new transfer may be sampled in ERR2, since HREADY is high.
- Completion cycle (pending OKAY, HREADYOUT=1):
  - Write: HWDATA is merged into the register at the closing edge.
    - Byte lanes selected little-endian from captured HSIZE/HADDR[1:0].
    - Byte: lane addr[1:0]. Half: lanes {addr[1],0}+{1,0}. Word: all lanes.
  - Read: HRDATA = register (or ID_VALUE) combinationally from the captured index. HRDATA=0 on every other cycle.
- Pipelining:
  - The next address phase overlaps the completion/ERR2 cycle.
  - A write committed at edge N is visible to a read whose data phase begins at N.
- Flat REG_OUT updates the cycle after the committing edge.
- The counter width is 4 bits; with WAIT_STATES=0 the counter logic is unused.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS and HSIZE encodings.
  - FSM state enum.
  - ID_INDEX=63.
  - HRESP codes OKAY/ERROR.
- One sub-module, ahblite_slave_ctrl, contains:
  - Address-phase capture, error classifier, wait counter and FSM.
  - Outputs: pending/commit strobe, captured index, byte-enable and HREADYOUT/HRESP.
- The top module holds the register bank and the read mux.

Test Plan:
- Reset, then idle bus with HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0, REG_OUT all 0.
- WAIT_STATES=2: word write 32'hDEADBEEF to 0x04, then read 0x04 -> write shows exactly 2 HREADYOUT-low cycles; the read completion cycle shows HRDATA=32'hDEADBEEF, HRESP=0.
- Byte write 8'hA5 to 0x07 over a register holding 32'h11223344 -> register becomes 32'hA5223344. Halfword write 16'h7788 to 0x06 -> 32'h77883344.
- Read of 0x02 with HSIZE=2 (unaligned) -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1; no register changes.
- Write to 0xFC (ID) -> two-cycle ERROR, ID unchanged. Read of 0xFC -> HRDATA=32'h5A5A0001, OKAY.
- WAIT_STATES=0: back-to-back NONSEQ write 0x00 then read 0x00, plus a HREADY-low stall inserted by another slave with HSEL asserted -> no capture during the stall, the read returns the new value, and a reset pulse mid-WAIT leaves the target register 0.
